// File: rtl/tpu_wb_sched.sv
// rtl/tpu_wb_sched.sv - write-back scheduler from result stream into SRAM banks a/b/c
// Optional stall cycle counter output enabled by WB_STALL_CNT_EN.
module tpu_wb_sched #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              sched_start,
  input  logic [6:0]        cfg_rows,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sram_write_enable_a0,
  output logic [DATA_W-1:0] sram_wdata_a,
  output logic [ADDR_W-1:0] sram_waddr_a,
  output logic              sram_write_enable_b0,
  output logic [DATA_W-1:0] sram_wdata_b,
  output logic [ADDR_W-1:0] sram_waddr_b,
  output logic              sram_write_enable_c0,
  output logic [DATA_W-1:0] sram_wdata_c,
  output logic [ADDR_W-1:0] sram_waddr_c,
`ifdef WB_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              sched_busy,
  output logic              sched_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wptr, rptr;
  logic [6:0]        eff_rows, cfg_eff, addr_cnt;
  logic [7:0]        total, acc_cnt, wr_cnt;
  logic [1:0]        bank;
  logic              fifo_full, fifo_empty, push, pop, start_ok;

  assign cfg_eff    = (cfg_rows > 7'd64) ? 7'd64 : cfg_rows;
  assign start_ok   = (state == IDLE) && sched_start;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                      (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  // Ready is a function of registered state only, so a same-cycle pop never widens it.
  assign in_ready   = (state == RUN) && !fifo_full && (acc_cnt < total);
  assign push       = in_valid && in_ready;
  assign pop        = (state == RUN) && !fifo_empty;
  assign sched_busy = (state != IDLE);
  assign sched_done = (state == DONE);

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sched_start) state_nxt = (cfg_eff == 7'd0) ? DONE : RUN;
      RUN:  if (wr_cnt == total) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[PTR_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      wptr <= '0;
      rptr <= '0;
      eff_rows <= '0;
      total <= '0;
      acc_cnt <= '0;
      wr_cnt <= '0;
      addr_cnt <= '0;
      bank <= '0;
      sram_write_enable_a0 <= 1'b1;
      sram_write_enable_b0 <= 1'b1;
      sram_write_enable_c0 <= 1'b1;
      sram_wdata_a <= '0;
      sram_wdata_b <= '0;
      sram_wdata_c <= '0;
      sram_waddr_a <= '0;
      sram_waddr_b <= '0;
      sram_waddr_c <= '0;
    end else begin
      sram_write_enable_a0 <= 1'b1;
      sram_write_enable_b0 <= 1'b1;
      sram_write_enable_c0 <= 1'b1;
      if (start_ok) begin
        eff_rows <= cfg_eff;
        total    <= {1'b0, cfg_eff} + {cfg_eff, 1'b0};
        acc_cnt  <= '0;
        wr_cnt   <= '0;
        addr_cnt <= '0;
        bank     <= '0;
        wptr     <= '0;
        rptr     <= '0;
      end else begin
        if (push) begin
          wptr    <= wptr + 1'b1;
          acc_cnt <= acc_cnt + 8'd1;
        end
        if (pop) begin
          rptr   <= rptr + 1'b1;
          wr_cnt <= wr_cnt + 8'd1;
          case (bank)
            2'd0: begin
              sram_write_enable_a0 <= 1'b0;
              sram_wdata_a <= mem[rptr[PTR_W-1:0]];
              sram_waddr_a <= addr_cnt[ADDR_W-1:0];
            end
            2'd1: begin
              sram_write_enable_b0 <= 1'b0;
              sram_wdata_b <= mem[rptr[PTR_W-1:0]];
              sram_waddr_b <= addr_cnt[ADDR_W-1:0];
            end
            2'd2: begin
              sram_write_enable_c0 <= 1'b0;
              sram_wdata_c <= mem[rptr[PTR_W-1:0]];
              sram_waddr_c <= addr_cnt[ADDR_W-1:0];
            end
            default: ;
          endcase
          if (addr_cnt == eff_rows - 7'd1) begin
            addr_cnt <= '0;
            bank     <= bank + 2'd1;
          end else begin
            addr_cnt <= addr_cnt + 7'd1;
          end
        end
      end
    end
  end

`ifdef WB_STALL_CNT_EN
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_wb_sched.sv
// tb/tb_tpu_wb_sched.sv - directed self-checking bench for tpu_wb_sched
// Optional stall counter checks follow WB_STALL_CNT_EN.
module tb_tpu_wb_sched;

  logic         clk = 1'b0;
  logic         srstn = 1'b0;
  logic         sched_start = 1'b0;
  logic [6:0]   cfg_rows = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         sram_write_enable_a0, sram_write_enable_b0, sram_write_enable_c0;
  logic [127:0] sram_wdata_a, sram_wdata_b, sram_wdata_c;
  logic [5:0]   sram_waddr_a, sram_waddr_b, sram_waddr_c;
  logic         sched_busy, sched_done;
`ifdef WB_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  tpu_wb_sched dut (
    .clk(clk), .srstn(srstn), .sched_start(sched_start), .cfg_rows(cfg_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sram_write_enable_a0(sram_write_enable_a0), .sram_wdata_a(sram_wdata_a), .sram_waddr_a(sram_waddr_a),
    .sram_write_enable_b0(sram_write_enable_b0), .sram_wdata_b(sram_wdata_b), .sram_waddr_b(sram_waddr_b),
    .sram_write_enable_c0(sram_write_enable_c0), .sram_wdata_c(sram_wdata_c), .sram_waddr_c(sram_waddr_c),
`ifdef WB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .sched_busy(sched_busy), .sched_done(sched_done)
  );

  typedef struct {
    int           bank;
    int           addr;
    logic [127:0] data;
    int           cyc;
  } wr_t;

  wr_t wlog[$];
  wr_t w;
  int  tests = 0, fails = 0;
  int  cyc = 0, nlow;
  int  hs_cnt, done_cnt, done_cyc, first_hs_cyc, multi_low, ready_drop, exp_total, start_cyc;
  int  acc;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] data_of(int i);
    return {32'hD0D0_0000 + 32'(i), 32'(i * 7 + 1), 32'hFFFF_0000 ^ 32'(i), 32'(i)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (srstn) begin
      nlow = 0;
      if (!sram_write_enable_a0) begin
        nlow++; w.bank = 0; w.addr = int'(sram_waddr_a); w.data = sram_wdata_a; w.cyc = cyc; wlog.push_back(w);
      end
      if (!sram_write_enable_b0) begin
        nlow++; w.bank = 1; w.addr = int'(sram_waddr_b); w.data = sram_wdata_b; w.cyc = cyc; wlog.push_back(w);
      end
      if (!sram_write_enable_c0) begin
        nlow++; w.bank = 2; w.addr = int'(sram_waddr_c); w.data = sram_wdata_c; w.cyc = cyc; wlog.push_back(w);
      end
      if (nlow > 1) multi_low++;
      if (sched_busy && !sched_done && !in_ready && hs_cnt < exp_total) ready_drop++;
      if (in_valid && in_ready) begin
        if (hs_cnt == 0) first_hs_cyc = cyc;
        hs_cnt++;
      end
      if (sched_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_log(int total_rows);
    wlog.delete();
    hs_cnt = 0; done_cnt = 0; done_cyc = -1; first_hs_cyc = -1;
    multi_low = 0; ready_drop = 0; exp_total = total_rows;
  endtask

  task automatic do_start(int cfg);
    @(posedge clk); #1;
    cfg_rows = cfg[6:0];
    sched_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    sched_start = 1'b0;
  endtask

  // mode 0: valid held high; mode 1: idle cycle after each accept plus a 10-cycle gap after row 3
  task automatic feed(int n_offer, int mode, output int accepted);
    int  i, budget;
    logic rdy;
    i = 0; budget = 0;
    while (i < n_offer && done_cnt == 0 && budget < 3000) begin
      in_valid = 1'b1;
      in_data = data_of(i);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      budget++;
      if (rdy) begin
        i++;
        if (mode == 1) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
          if (i == 3) begin
            repeat (10) @(posedge clk);
            #1;
          end
        end
      end
    end
    in_valid = 1'b0;
    check("feed_budget", budget < 3000, 1);
    accepted = i;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (done_cnt == 0 && b < 500) begin
      @(posedge clk); #1;
      b++;
    end
    check("done_seen", done_cnt != 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic verify(int cfg, int n_exp, int accepted);
    int eff;
    eff = (cfg > 64) ? 64 : cfg;
    check("accepted", accepted, n_exp);
    check("n_writes", wlog.size(), n_exp);
    for (int r = 0; r < n_exp && r < wlog.size(); r++) begin
      check($sformatf("bank_r%0d", r), wlog[r].bank, r / eff);
      check($sformatf("addr_r%0d", r), wlog[r].addr, r % eff);
      check($sformatf("data_r%0d", r), wlog[r].data, data_of(r));
    end
    check("multi_low", multi_low, 0);
    check("ready_drop", ready_drop, 0);
    check("done_count", done_cnt, 1);
    if (n_exp > 0 && wlog.size() > 0) begin
      check("done_timing", done_cyc, wlog[wlog.size() - 1].cyc + 1);
      check("first_latency", wlog[0].cyc - first_hs_cyc, 2);
    end
    check("busy_after", sched_busy, 0);
  endtask

  task automatic run_case(int cfg, int n_offer, int mode, int n_exp);
    clear_log(n_exp);
    do_start(cfg);
    feed(n_offer, mode, acc);
    wait_done();
    verify(cfg, n_exp, acc);
  endtask

  task automatic check_reset_outputs(string pfx);
    check({pfx, "_we_a"}, sram_write_enable_a0, 1);
    check({pfx, "_we_b"}, sram_write_enable_b0, 1);
    check({pfx, "_we_c"}, sram_write_enable_c0, 1);
    check({pfx, "_wdata"}, sram_wdata_a | sram_wdata_b | sram_wdata_c, 0);
    check({pfx, "_waddr"}, {sram_waddr_a, sram_waddr_b, sram_waddr_c}, 0);
    check({pfx, "_ready"}, in_ready, 0);
    check({pfx, "_busy"}, sched_busy, 0);
    check({pfx, "_done"}, sched_done, 0);
  endtask

  initial begin
    clear_log(0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
`ifdef WB_STALL_CNT_EN
    check("reset_stall", stall_cnt, 0);
`endif
    srstn = 1'b1;

    run_case(4, 12, 0, 12);
    run_case(64, 192, 0, 192);
    run_case(2, 6, 1, 6);

    run_case(3, 12, 0, 9);
`ifdef WB_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 2);
`endif

    clear_log(0);
    do_start(0);
    wait_done();
    check("zero_writes", wlog.size(), 0);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_done_cyc", done_cyc, start_cyc + 1);

    run_case(100, 192, 0, 192);

    clear_log(12);
    do_start(4);
    feed(5, 0, acc);
    srstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    srstn = 1'b1;
    clear_log(12);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_writes", wlog.size(), 0);
    run_case(4, 12, 0, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tpu_wb_sched.md
Name: tpu_wb_sched

Overview:
Write-back scheduler between the systolic array result stream and the three output SRAM banks (a, b, c) of tpu_top.
- Accepts 128-bit result rows over a valid/ready handshake and buffers them in a small FIFO.
- Distributes rows sequentially: cfg_rows rows to bank a, then bank b, then bank c.
- Generates per-bank write strobes and addresses, and signals completion to the top-level controller.

Parameters:
DATA_W, 128, result row width and SRAM wdata width
ADDR_W, 6, SRAM write address width (64 rows per bank)
FIFO_DEPTH, 4, input buffer entries; power of 2, at least 2

Ports:
clk  input  1  clock; all logic on rising edge
srstn  input  1  asynchronous active-low reset
sched_start  input  1  one-cycle start request; sampled only in IDLE
cfg_rows  input  7  rows per bank; latched on accepted start
in_valid  input  1  result row valid
in_ready  output  1  scheduler can accept a row
in_data  input  DATA_W  result row
sram_write_enable_a0  output  1  bank a write strobe, active-low
sram_wdata_a  output  DATA_W  bank a write data
sram_waddr_a  output  ADDR_W  bank a write address
sram_write_enable_b0  output  1  bank b write strobe, active-low
sram_wdata_b  output  DATA_W  bank b write data
sram_waddr_b  output  ADDR_W  bank b write address
sram_write_enable_c0  output  1  bank c write strobe, active-low
sram_wdata_c  output  DATA_W  bank c write data
sram_waddr_c  output  ADDR_W  bank c write address
sched_busy  output  1  high in RUN and DONE
sched_done  output  1  one-cycle completion pulse

Behaviour:
Reset values
- All three write enables = 1.
- All wdata = 0; all waddr = 0.
- in_ready = 0, sched_busy = 0, sched_done = 0.
- FIFO empty; all counters = 0; state = IDLE.
- Reset asserted mid-operation aborts immediately: buffered rows are discarded and no further writes occur.

Start and configuration
- States: IDLE, RUN, DONE.
- IDLE: on sched_start=1, latch eff_rows = min(cfg_rows, 64), compute total = 3*eff_rows, clear the accepted and written counters, then go to RUN.
- eff_rows = 0: go to DONE with no writes.
- sched_start outside IDLE is ignored.

RUN
- in_ready = 1 when FIFO not full AND accepted < total. It depends only on the current state, not on a same-cycle pop.
- A row is accepted when in_valid & in_ready; it is pushed into the FIFO.
- When the FIFO is non-empty, pop one row per cycle into registered outputs.
- Written index r (0..total-1) selects bank = r / eff_rows and addr = r mod eff_rows.
- On a pop, the selected bank's write enable is 0 for exactly one cycle, with its wdata/waddr set to the row and addr.
- Non-selected banks keep write enable = 1 and hold their last wdata/waddr.
- Latency: a row accepted in cycle t produces its write strobe in cycle t+2 at the earliest. Throughput is 1 row/cycle.
- Push and pop in the same cycle are legal; FIFO occupancy is then unchanged.
- Bank switch: after addr eff_rows-1, the next row goes to the next bank at addr 0. With eff_rows = 64 the 6-bit address wraps 63 -> 0.

DONE
- Entered the cycle after the write strobe for r = total-1.
- sched_done = 1 for one cycle, in_ready = 0, then return to IDLE.
- Extra in_valid beyond total rows is never accepted; in_ready stays 0.

Optional Feature:
Macro: WB_STALL_CNT_EN
- Defined: adds output port stall_cnt (16 bits).
  - Counts cycles in RUN with in_valid=1 and in_ready=0.
  - Saturates at 0xFFFF; cleared on accepted start and on reset; held in IDLE.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. cfg_rows=4, start, 12 back-to-back rows D0..D11 with in_valid held high:
   - -> bank a writes D0..D3 at addr 0..3, b writes D4..D7, c writes D8..D11.
   - -> first strobe 2 cycles after the first handshake.
   - -> sched_done pulses once, the cycle after the D11 write.
2. cfg_rows=64, 192 rows -> bank a addr 63 is followed by bank b addr 0; exactly 192 strobes; only one write enable low in any cycle.
3. cfg_rows=2 with in_valid toggling every other cycle, then a 10-cycle gap mid-stream -> correct bank/addr sequence, no spurious strobes, in_ready never drops while the FIFO is non-full.
4. cfg_rows=3 with 12 valid rows offered -> in_ready falls after 9 accepts; rows 10..12 are never written; with WB_STALL_CNT_EN, stall_cnt counts blocked cycles.
5. cfg_rows=0 -> sched_done one cycle after start, no writes. cfg_rows=100 -> behaves as 64.
6. Assert srstn low after 5 of 12 rows (cfg_rows=4) -> all outputs return to reset values immediately; a new start writes bank a from addr 0.
